pc_sequencer: RTL and testbench

Parametrised program sequencer that generates the instruction fetch address for the control unit. It supersedes the plain load/increment counter and adds configurable address width, a reset vector, signed relative branches, and an optional hardware return-address stack for call/return. It sits between the instruction decoder, which drives the control strobes, and instruction memory, which consumes `pc`.

---
 rtl/pc_sequencer_if.sv | 35 +++
 rtl/pc_sequencer.sv | 143 ++++++++++++++
 tb/tb_pc_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Bundle of control strobes and status outputs between the instruction
// decoder (master) and the program sequencer (slave).
interface pc_sequencer_if #(
  parameter int ADDR_W      = 8,
  parameter int OFF_W       = 6,
  parameter int STACK_DEPTH = 4
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic              inc;
  logic              load;
  logic              branch;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] target;
  logic [OFF_W-1:0]  offset;
  logic [ADDR_W-1:0] pc;
  logic [SP_W-1:0]   sp;
  logic              stack_empty;
  logic              stack_full;
  logic              err;
  logic              err_sticky;

  // Decoder side: drives strobes, observes the fetch address and status.
  modport master (
    output inc, load, branch, call, ret, target, offset,
    input  pc, sp, stack_empty, stack_full, err, err_sticky
  );

  // Sequencer side.
  modport slave (
    input  inc, load, branch, call, ret, target, offset,
    output pc, sp, stack_empty, stack_full, err, err_sticky
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program sequencer: generates the instruction fetch address with
// increment, absolute load, signed relative branch and call/return.
// Optional return-address stack enabled by defining PC_STACK_EN; without it
// call acts as load and ret is always an error.
module pc_sequencer #(
  parameter int          ADDR_W       = 8,
  parameter int          OFF_W        = 6,
  parameter int          STACK_DEPTH  = 4,
  parameter int unsigned RESET_VECTOR = 0
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_LOAD,
    OP_CALL,
    OP_RET,
    OP_BRANCH,
    OP_INC
  } op_e;

  logic [ADDR_W-1:0] r_pc;
  logic              r_err;
  logic              r_err_sticky;

  op_e               w_op;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_err_next;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_off_ext;

  assign w_pc_inc  = r_pc + ADDR_W'(1);
  // Size cast of a signed operand sign-extends the offset to the pc width.
  assign w_off_ext = ADDR_W'($signed(bus.offset));

`ifdef PC_STACK_EN
  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
  logic [SP_W-1:0]   r_sp;
  logic [SP_W-1:0]   w_sp_next;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic [IDX_W-1:0]  w_top_idx;

  assign w_full    = (r_sp == SP_W'(STACK_DEPTH));
  assign w_empty   = (r_sp == '0);
  assign w_top_idx = IDX_W'(r_sp - SP_W'(1));
`endif

  // Fixed-priority strobe decode: only the winning action has any effect.
  always_comb begin
    w_op = OP_HOLD;
    if (bus.load)        w_op = OP_LOAD;
    else if (bus.call)   w_op = OP_CALL;
    else if (bus.ret)    w_op = OP_RET;
    else if (bus.branch) w_op = OP_BRANCH;
    else if (bus.inc)    w_op = OP_INC;
  end

  // Next pc / stack pointer / error for the selected action.
  always_comb begin
    w_pc_next  = r_pc;
    w_err_next = 1'b0;
`ifdef PC_STACK_EN
    w_sp_next  = r_sp;
    w_push     = 1'b0;
`endif
    case (w_op)
      OP_LOAD: w_pc_next = bus.target;
      OP_CALL: begin
`ifdef PC_STACK_EN
        if (!w_full) begin
          w_push    = 1'b1;
          w_sp_next = r_sp + SP_W'(1);
          w_pc_next = bus.target;
        end else begin
          w_err_next = 1'b1;
        end
`else
        w_pc_next = bus.target;
`endif
      end
      OP_RET: begin
`ifdef PC_STACK_EN
        if (!w_empty) begin
          w_pc_next = r_stack[w_top_idx];
          w_sp_next = r_sp - SP_W'(1);
        end else begin
          w_err_next = 1'b1;
        end
`else
        w_err_next = 1'b1;
`endif
      end
      OP_BRANCH: w_pc_next = r_pc + w_off_ext;
      OP_INC:    w_pc_next = w_pc_inc;
      default:   ;
    endcase
  end

  // Architectural state; reset overrides any strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= ADDR_W'(RESET_VECTOR);
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_pc         <= w_pc_next;
      r_err        <= w_err_next;
      r_err_sticky <= r_err_sticky | w_err_next;
    end
  end

`ifdef PC_STACK_EN
  // Stack pointer; contents are deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (reset) r_sp <= '0;
    else       r_sp <= w_sp_next;
  end

  // Return-address storage written at the current top on a legal call.
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_stack[IDX_W'(r_sp)] <= w_pc_inc;
  end

  assign bus.sp          = r_sp;
  assign bus.stack_empty = w_empty;
  assign bus.stack_full  = w_full;
`else
  assign bus.sp          = '0;
  assign bus.stack_empty = 1'b1;
  assign bus.stack_full  = 1'b0;
`endif

  assign bus.pc         = r_pc;
  assign bus.err        = r_err;
  assign bus.err_sticky = r_err_sticky;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (ADDR_W=8, OFF_W=6, STACK_DEPTH=4,
// RESET_VECTOR=0). Stack scenarios run when PC_STACK_EN is defined;
// otherwise the stackless behaviour is exercised.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  pc_sequencer_if #(.ADDR_W(8), .OFF_W(6), .STACK_DEPTH(4)) bus ();

  pc_sequencer #(
    .ADDR_W(8), .OFF_W(6), .STACK_DEPTH(4), .RESET_VECTOR(0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // One clock with the given strobes; outputs are sampled 1 time unit
  // after the edge, then all strobes are released.
  task automatic drive(input logic rst, input logic ld, input logic cl,
                       input logic rt, input logic br, input logic in,
                       input logic [7:0] tgt, input logic [5:0] off);
    reset = rst; bus.load = ld; bus.call = cl; bus.ret = rt;
    bus.branch = br; bus.inc = in; bus.target = tgt; bus.offset = off;
    @(posedge clk);
    #1;
    $display("t=%0t rst=%b ld=%b cl=%b rt=%b br=%b in=%b tgt=%h off=%h -> pc=%h sp=%0d e=%b f=%b err=%b stk=%b",
             $time, rst, ld, cl, rt, br, in, tgt, off, bus.pc, bus.sp,
             bus.stack_empty, bus.stack_full, bus.err, bus.err_sticky);
    reset = 1'b0; bus.load = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;
    bus.branch = 1'b0; bus.inc = 1'b0;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 1, 8'h00, 6'h00);
    checks++; if (bus.pc !== 8'h00) begin errors++; $display("FAIL reset_pc got %h want 00", bus.pc); end
    checks++; if (bus.sp !== 3'd0) begin errors++; $display("FAIL reset_sp got %0d want 0", bus.sp); end
    checks++; if (bus.stack_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", bus.stack_empty); end
    checks++; if (bus.stack_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.stack_full); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err); end
    checks++; if (bus.err_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b want 0", bus.err_sticky); end
  endtask

  task automatic test_increment();
    logic [7:0] exp_pc [3];
    exp_pc = '{8'h01, 8'h02, 8'h03};
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 1, 8'h00, 6'h00);
      checks++; if (bus.pc !== exp_pc[i]) begin errors++; $display("FAIL inc_%0d got %h want %h", i, bus.pc, exp_pc[i]); end
    end
    drive(0, 1, 0, 0, 0, 0, 8'hFF, 6'h00);
    checks++; if (bus.pc !== 8'hFF) begin errors++; $display("FAIL load_ff got %h want ff", bus.pc); end
    drive(0, 0, 0, 0, 0, 1, 8'h00, 6'h00);
    checks++; if (bus.pc !== 8'h00) begin errors++; $display("FAIL inc_wrap got %h want 00", bus.pc); end
    drive(0, 0, 0, 0, 0, 0, 8'h77, 6'h00);
    checks++; if (bus.pc !== 8'h00) begin errors++; $display("FAIL hold got %h want 00", bus.pc); end
  endtask

  task automatic test_priority();
    drive(0, 1, 0, 0, 1, 1, 8'h40, 6'h05);
    checks++; if (bus.pc !== 8'h40) begin errors++; $display("FAIL prio_load got %h want 40", bus.pc); end
    drive(0, 0, 0, 0, 1, 1, 8'h00, 6'h02);
    checks++; if (bus.pc !== 8'h42) begin errors++; $display("FAIL prio_branch got %h want 42", bus.pc); end
    drive(0, 0, 1, 1, 0, 0, 8'h20, 6'h00);
    checks++; if (bus.pc !== 8'h20) begin errors++; $display("FAIL prio_call_pc got %h want 20", bus.pc); end
`ifdef PC_STACK_EN
    checks++; if (bus.sp !== 3'd1) begin errors++; $display("FAIL prio_call_sp got %0d want 1", bus.sp); end
    drive(0, 0, 0, 1, 0, 0, 8'h00, 6'h00);
    checks++; if (bus.pc !== 8'h43) begin errors++; $display("FAIL prio_ret_pc got %h want 43", bus.pc); end
    checks++; if (bus.sp !== 3'd0) begin errors++; $display("FAIL prio_ret_sp got %0d want 0", bus.sp); end
`else
    checks++; if (bus.sp !== 3'd0) begin errors++; $display("FAIL prio_call_sp got %0d want 0", bus.sp); end
`endif
  endtask

  task automatic test_branch();
    drive(0, 1, 0, 0, 0, 0, 8'h40, 6'h00);
    drive(0, 0, 0, 0, 1, 0, 8'h00, 6'h3D);
    checks++; if (bus.pc !== 8'h3D) begin errors++; $display("FAIL branch_back got %h want 3d", bus.pc); end
    drive(0, 1, 0, 0, 0, 0, 8'hFE, 6'h00);
    drive(0, 0, 0, 0, 1, 0, 8'h00, 6'h05);
    checks++; if (bus.pc !== 8'h03) begin errors++; $display("FAIL branch_fwd_wrap got %h want 03", bus.pc); end
    drive(0, 0, 0, 0, 1, 0, 8'h00, 6'h3B);
    checks++; if (bus.pc !== 8'hFE) begin errors++; $display("FAIL branch_back_wrap got %h want fe", bus.pc); end
    drive(0, 0, 0, 0, 1, 0, 8'h00, 6'h20);
    checks++; if (bus.pc !== 8'hDE) begin errors++; $display("FAIL branch_min got %h want de", bus.pc); end
  endtask

`ifdef PC_STACK_EN
  task automatic test_call_return();
    drive(0, 1, 0, 0, 0, 0, 8'h10, 6'h00);
    drive(0, 0, 1, 0, 0, 0, 8'h80, 6'h00);
    checks++; if (bus.pc !== 8'h80) begin errors++; $display("FAIL call_pc got %h want 80", bus.pc); end
    checks++; if (bus.sp !== 3'd1) begin errors++; $display("FAIL call_sp got %0d want 1", bus.sp); end
    drive(0, 0, 0, 1, 0, 0, 8'h00, 6'h00);
    checks++; if (bus.pc !== 8'h11) begin errors++; $display("FAIL ret_pc got %h want 11", bus.pc); end
    checks++; if (bus.sp !== 3'd0) begin errors++; $display("FAIL ret_sp got %0d want 0", bus.sp); end
    checks++; if (bus.stack_empty !== 1'b1) begin errors++; $display("FAIL ret_empty got %b want 1", bus.stack_empty); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] tgt   [4];
    logic [7:0] ret_a [4];
    tgt   = '{8'h10, 8'h20, 8'h30, 8'h40};
    ret_a = '{8'h31, 8'h21, 8'h11, 8'h06};
    drive(0, 1, 0, 0, 0, 0, 8'h05, 6'h00);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0, 0, 0, tgt[i], 6'h00);
      checks++; if (bus.pc !== tgt[i] || bus.sp !== 3'(i + 1)) begin errors++; $display("FAIL fill_%0d got pc=%h sp=%0d want pc=%h sp=%0d", i, bus.pc, bus.sp, tgt[i], i + 1); end
    end
    checks++; if (bus.stack_full !== 1'b1 || bus.err !== 1'b0) begin errors++; $display("FAIL full_flag got full=%b err=%b want 1 0", bus.stack_full, bus.err); end
    drive(0, 0, 1, 0, 0, 0, 8'h50, 6'h00);
    checks++; if (bus.pc !== 8'h40 || bus.sp !== 3'd4) begin errors++; $display("FAIL overflow_hold got pc=%h sp=%0d want 40 4", bus.pc, bus.sp); end
    checks++; if (bus.err !== 1'b1 || bus.err_sticky !== 1'b1) begin errors++; $display("FAIL overflow_err got err=%b stk=%b want 1 1", bus.err, bus.err_sticky); end
    drive(0, 0, 0, 0, 0, 0, 8'h00, 6'h00);
    checks++; if (bus.err !== 1'b0 || bus.err_sticky !== 1'b1) begin errors++; $display("FAIL overflow_pulse got err=%b stk=%b want 0 1", bus.err, bus.err_sticky); end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 0, 0, 8'h00, 6'h00);
      checks++; if (bus.pc !== ret_a[i] || bus.sp !== 3'(3 - i)) begin errors++; $display("FAIL unwind_%0d got pc=%h sp=%0d want pc=%h sp=%0d", i, bus.pc, bus.sp, ret_a[i], 3 - i); end
    end
    drive(0, 0, 0, 1, 0, 0, 8'h00, 6'h00);
    checks++; if (bus.pc !== 8'h06 || bus.err !== 1'b1 || bus.sp !== 3'd0) begin errors++; $display("FAIL underflow got pc=%h err=%b sp=%0d want 06 1 0", bus.pc, bus.err, bus.sp); end
    drive(0, 0, 0, 0, 0, 0, 8'h00, 6'h00);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL underflow_pulse got %b want 0", bus.err); end
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 1, 0, 0, 0, 8'h10, 6'h00);
    drive(0, 0, 1, 0, 0, 0, 8'h20, 6'h00);
    checks++; if (bus.sp !== 3'd2 || bus.err_sticky !== 1'b1) begin errors++; $display("FAIL mid_setup got sp=%0d stk=%b want 2 1", bus.sp, bus.err_sticky); end
    drive(1, 0, 1, 0, 0, 0, 8'h99, 6'h00);
    checks++; if (bus.pc !== 8'h00 || bus.sp !== 3'd0) begin errors++; $display("FAIL mid_reset got pc=%h sp=%0d want 00 0", bus.pc, bus.sp); end
    checks++; if (bus.err_sticky !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL mid_reset_err got err=%b stk=%b want 0 0", bus.err, bus.err_sticky); end
  endtask
`else
  task automatic test_no_stack();
    drive(0, 0, 1, 0, 0, 0, 8'h30, 6'h00);
    checks++; if (bus.pc !== 8'h30 || bus.sp !== 3'd0) begin errors++; $display("FAIL nostack_call got pc=%h sp=%0d want 30 0", bus.pc, bus.sp); end
    checks++; if (bus.stack_empty !== 1'b1 || bus.stack_full !== 1'b0) begin errors++; $display("FAIL nostack_flags got e=%b f=%b want 1 0", bus.stack_empty, bus.stack_full); end
    drive(0, 0, 0, 1, 0, 1, 8'h00, 6'h00);
    checks++; if (bus.pc !== 8'h30 || bus.err !== 1'b1 || bus.err_sticky !== 1'b1) begin errors++; $display("FAIL nostack_ret got pc=%h err=%b stk=%b want 30 1 1", bus.pc, bus.err, bus.err_sticky); end
    drive(0, 0, 0, 0, 0, 1, 8'h00, 6'h00);
    checks++; if (bus.pc !== 8'h31 || bus.err !== 1'b0 || bus.err_sticky !== 1'b1) begin errors++; $display("FAIL nostack_after got pc=%h err=%b stk=%b want 31 0 1", bus.pc, bus.err, bus.err_sticky); end
    drive(1, 0, 0, 0, 0, 0, 8'h00, 6'h00);
    checks++; if (bus.pc !== 8'h00 || bus.err_sticky !== 1'b0) begin errors++; $display("FAIL nostack_reset got pc=%h stk=%b want 00 0", bus.pc, bus.err_sticky); end
  endtask
`endif

  initial begin
    reset = 1'b1; bus.load = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;
    bus.branch = 1'b0; bus.inc = 1'b0; bus.target = '0; bus.offset = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_increment();
    test_priority();
    test_branch();
`ifdef PC_STACK_EN
    test_call_return();
    test_back_to_back();
    test_reset_mid();
`else
    test_no_stack();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
